// File: rtl/conv1d_pkg.sv
// Shared definitions for the shift-and-add 1-D convolution block:
// controller state encoding, size limits and a constant-time clog2.
package conv1d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        RUN   = 2'b10,
        FLUSH = 2'b11
    } state_t;

    localparam int MAX_TAPS = 8;
    localparam int GUARD_W  = 3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv1d_sat.sv
// Output stage: narrows the guard-extended accumulator back to DW bits,
// either clamping to the signed range or keeping the low bits.
module conv1d_sat
    import conv1d_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic signed [DW+GUARD_W-1:0] din,
    input  logic                         sat_en,
    output logic signed [DW-1:0]         dout
);
    localparam int AW = DW + GUARD_W;

    // Overflow means the guard bits and the DW sign bit disagree.
    function automatic logic signed [DW-1:0] fold(input logic signed [AW-1:0] v,
                                                  input logic en);
        logic ovf;
        ovf = (v[AW-1:DW-1] != {(GUARD_W + 1){v[AW-1]}});
        if (en && ovf) begin
            return v[AW-1] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
        end
        return v[DW-1:0];
    endfunction

    assign dout = fold(din, sat_en);

endmodule

// File: rtl/conv1d_shift.sv
// Streaming 1-D filter whose taps are arithmetic right shifts; a small
// controller primes the window, emits one result per accept and flushes frames.
module conv1d_shift
    import conv1d_pkg::*;
#(
    parameter int                DW     = 8,
    parameter int                TAPS   = 3,
    parameter logic [3*TAPS-1:0] SHIFTS = {3'd2, 3'd1, 3'd2},
    parameter bit                SAT    = 1'b1,
    parameter bit                PRIME  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic signed [DW-1:0] in,
    input  logic                 i_en,
    input  logic                 i_last,
    output logic                 i_rdy,
    output logic signed [DW-1:0] out,
    output logic                 o_en
);
    localparam int            AW        = DW + GUARD_W;
    localparam int            CW        = clog2(MAX_TAPS);
    localparam logic [CW-1:0] CNT_FULL  = CW'(TAPS - 1);
    localparam logic [CW-1:0] FLUSH_END = CW'(TAPS - 2);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        fcnt_q, fcnt_d;
    logic signed [DW-1:0] w_q [TAPS-1];
    logic signed [DW-1:0] w_d [TAPS-1];
    logic signed [DW-1:0] out_q, out_d;
    logic                 o_en_q, o_en_d;
    logic signed [DW-1:0] tap [TAPS];
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] res;
    logic                 flushing;
    logic                 accept;

    assign flushing = (state_q == FLUSH);
    assign i_rdy    = !flushing;
    assign accept   = i_en && i_rdy;

    // Datapath: during a flush the newest tap is a zero instead of the input.
    always_comb begin : p_acc
        logic signed [AW-1:0] ext;
        ext    = '0;
        tap[0] = flushing ? '0 : in;
        for (int k = 1; k < TAPS; k++) tap[k] = w_q[k-1];
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            ext = AW'(tap[k]);
            acc = acc + (ext >>> SHIFTS[3*k +: 3]);
        end
    end

    conv1d_sat #(.DW(DW)) u_sat (
        .din    (acc),
        .sat_en (SAT),
        .dout   (res)
    );

    always_comb begin : p_next
        logic emit;
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        w_d     = w_q;
        out_d   = out_q;
        o_en_d  = 1'b0;
        emit    = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            fcnt_d  = '0;
            out_d   = '0;
            for (int k = 0; k < TAPS - 1; k++) w_d[k] = '0;
        end else if (flushing) begin
            // cnt is frozen here, so it still says whether the window ever filled.
            emit   = !PRIME || (cnt_q == CNT_FULL);
            w_d[0] = '0;
            for (int k = 1; k < TAPS - 1; k++) w_d[k] = w_q[k-1];
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == FLUSH_END) begin
                state_d = IDLE;
                cnt_d   = '0;
                fcnt_d  = '0;
                for (int k = 0; k < TAPS - 1; k++) w_d[k] = '0;
            end
        end else if (accept) begin
            emit   = !PRIME || (cnt_q == CNT_FULL);
            w_d[0] = in;
            for (int k = 1; k < TAPS - 1; k++) w_d[k] = w_q[k-1];
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
            state_d = (cnt_d == CNT_FULL) ? RUN : FILL;
            if (i_last) begin
                state_d = FLUSH;
                fcnt_d  = '0;
            end
        end
        if (emit) begin
            o_en_d = 1'b1;
            out_d  = res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            out_q   <= '0;
            o_en_q  <= 1'b0;
            for (int k = 0; k < TAPS - 1; k++) w_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            out_q   <= out_d;
            o_en_q  <= o_en_d;
            w_q     <= w_d;
        end
    end

    assign out  = out_q;
    assign o_en = o_en_q;

endmodule

// File: tb/tb_conv1d_shift.sv
// Bench for conv1d_shift: four configurations share one stimulus stream and
// each is compared every cycle against a sample-history reference model.
module tb_conv1d_shift;
    localparam int DW   = 8;
    localparam int TAPS = 3;
    localparam int NU   = 4;

    logic                 clk = 1'b0;
    logic                 rst, clr, i_en, i_last;
    logic signed [DW-1:0] in_s;
    logic                 rdy0, rdy1, rdy2, rdy3;
    logic                 oen0, oen1, oen2, oen3;
    logic signed [DW-1:0] out0, out1, out2, out3;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    int m_hist [NU][TAPS];
    int m_n    [NU];
    int m_fl   [NU];
    int m_out  [NU];
    bit m_oen  [NU];
    int cfg_sh [NU][TAPS];
    bit cfg_sat[NU];
    bit cfg_pr [NU];

    always #5 clk = ~clk;

    conv1d_shift u_def (
        .clk(clk), .rst(rst), .clr(clr), .in(in_s), .i_en(i_en), .i_last(i_last),
        .i_rdy(rdy0), .out(out0), .o_en(oen0));
    conv1d_shift #(.SHIFTS(9'd0), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .in(in_s), .i_en(i_en), .i_last(i_last),
        .i_rdy(rdy1), .out(out1), .o_en(oen1));
    conv1d_shift #(.SHIFTS(9'd0), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .in(in_s), .i_en(i_en), .i_last(i_last),
        .i_rdy(rdy2), .out(out2), .o_en(oen2));
    conv1d_shift #(.PRIME(1'b0)) u_nopr (
        .clk(clk), .rst(rst), .clr(clr), .in(in_s), .i_en(i_en), .i_last(i_last),
        .i_rdy(rdy3), .out(out3), .o_en(oen3));

    function automatic integer dut_out(int c);
        case (c)
            0: return out0;
            1: return out1;
            2: return out2;
            default: return out3;
        endcase
    endfunction

    function automatic integer dut_oen(int c);
        case (c)
            0: return {31'd0, oen0};
            1: return {31'd0, oen1};
            2: return {31'd0, oen2};
            default: return {31'd0, oen3};
        endcase
    endfunction

    function automatic integer dut_rdy(int c);
        case (c)
            0: return {31'd0, rdy0};
            1: return {31'd0, rdy1};
            2: return {31'd0, rdy2};
            default: return {31'd0, rdy3};
        endcase
    endfunction

    // Reference: true sum of floor(sample / 2^shift), then clamp or wrap to DW bits.
    function automatic int fold(int v, bit s);
        int r;
        if (s) begin
            r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
        end else begin
            r = v & 255;
            if (r > 127) r = r - 256;
        end
        return r;
    endfunction

    function automatic int win_sum(int c);
        int v;
        v = 0;
        for (int k = 0; k < TAPS; k++) v = v + (m_hist[c][k] >>> cfg_sh[c][k]);
        return fold(v, cfg_sat[c]);
    endfunction

    function automatic void push(int c, int x);
        for (int k = TAPS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = x;
    endfunction

    function automatic void clear_unit(int c);
        for (int k = 0; k < TAPS; k++) m_hist[c][k] = 0;
        m_n[c]  = 0;
        m_fl[c] = 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NU; c++) begin
            clear_unit(c);
            m_out[c] = 0;
            m_oen[c] = 1'b0;
        end
    endfunction

    function automatic void model_step(bit cl, bit en, bit last, int x);
        for (int c = 0; c < NU; c++) begin
            m_oen[c] = 1'b0;
            if (cl) begin
                clear_unit(c);
                m_out[c] = 0;
            end else if (m_fl[c] > 0) begin
                push(c, 0);
                if (!cfg_pr[c] || m_n[c] == TAPS - 1) begin
                    m_oen[c] = 1'b1;
                    m_out[c] = win_sum(c);
                end
                m_fl[c] = m_fl[c] - 1;
                if (m_fl[c] == 0) clear_unit(c);
            end else if (en) begin
                push(c, x);
                if (!cfg_pr[c] || m_n[c] == TAPS - 1) begin
                    m_oen[c] = 1'b1;
                    m_out[c] = win_sum(c);
                end
                if (m_n[c] < TAPS - 1) m_n[c] = m_n[c] + 1;
                if (last) m_fl[c] = TAPS - 1;
            end
        end
    endfunction

    task automatic chk(string tag, integer obs, integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NU; c++) begin
            chk($sformatf("c%0d_out_u%0d", ncyc, c), dut_out(c), m_out[c]);
            chk($sformatf("c%0d_oen_u%0d", ncyc, c), dut_oen(c), {31'd0, m_oen[c]});
            chk($sformatf("c%0d_rdy_u%0d", ncyc, c), dut_rdy(c), (m_fl[c] == 0) ? 1 : 0);
        end
    endtask

    task automatic cyc(bit cl, bit en, bit last, int x);
        clr    = cl;
        i_en   = en;
        i_last = last;
        in_s   = DW'(x);
        @(posedge clk);
        model_step(cl, en, last, x);
        ncyc++;
        #1;
        check_all();
    endtask

    task automatic check_idle_zero(string tag);
        for (int c = 0; c < NU; c++) begin
            chk($sformatf("%s_out_u%0d", tag, c), dut_out(c), 0);
            chk($sformatf("%s_oen_u%0d", tag, c), dut_oen(c), 0);
            chk($sformatf("%s_rdy_u%0d", tag, c), dut_rdy(c), 1);
        end
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; i_en = 1'b0; i_last = 1'b0; in_s = '0;
        for (int c = 0; c < NU; c++) begin
            cfg_sat[c] = 1'b1;
            cfg_pr[c]  = 1'b1;
            cfg_sh[c][0] = 2; cfg_sh[c][1] = 1; cfg_sh[c][2] = 2;
        end
        for (int k = 0; k < TAPS; k++) begin
            cfg_sh[1][k] = 0;
            cfg_sh[2][k] = 0;
        end
        cfg_sat[2] = 1'b0;
        cfg_pr[3]  = 1'b0;
        model_reset();

        #12;
        check_idle_zero("reset");
        rst = 1'b1;

        // Prime, run, then a frame end and its two flush outputs
        cyc(0, 1, 0, 64);
        cyc(0, 1, 0, 64);
        chk("fill_oen", {31'd0, oen0}, 0);
        cyc(0, 1, 0, 64);
        chk("run_out", out0, 64);
        chk("run_oen", {31'd0, oen0}, 1);
        cyc(0, 1, 1, 64);
        chk("last_out", out0, 64);
        chk("flush_rdy0", {31'd0, rdy0}, 0);
        cyc(0, 1, 0, 99);
        chk("flush1_out", out0, 48);
        chk("flush_rdy1", {31'd0, rdy0}, 0);
        cyc(0, 1, 0, 99);
        chk("flush2_out", out0, 16);
        chk("flush2_oen", {31'd0, oen0}, 1);
        chk("rdy_back", {31'd0, rdy0}, 1);

        // Overflow: saturate versus wrap
        cyc(0, 1, 0, 127);
        cyc(0, 1, 0, 127);
        cyc(0, 1, 0, 127);
        chk("sat_max", out1, 127);
        chk("wrap_low", out2, 125);
        cyc(0, 0, 0, 0);
        chk("hold_out", out1, 127);
        chk("hold_oen", {31'd0, oen1}, 0);

        // Most negative input
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, -128);
        chk("neg_single", out3, -32);
        cyc(0, 1, 0, -128);
        cyc(0, 1, 0, -128);
        chk("neg_min", out0, -128);

        // Unprimed single-sample frame
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 64);
        chk("np_s0", out3, 16);
        chk("np_e0", {31'd0, oen3}, 1);
        cyc(0, 0, 0, 0);
        chk("np_s1", out3, 32);
        cyc(0, 0, 0, 0);
        chk("np_s2", out3, 16);
        chk("np_e2", {31'd0, oen3}, 1);
        cyc(0, 0, 0, 0);
        chk("np_idle", {31'd0, oen3}, 0);

        // Clear in the first flush cycle with a competing i_en
        cyc(0, 1, 0, 64);
        cyc(0, 1, 0, 64);
        cyc(0, 1, 0, 64);
        cyc(0, 1, 1, 64);
        cyc(1, 1, 0, 50);
        chk("clr_out", out0, 0);
        chk("clr_oen", {31'd0, oen0}, 0);
        chk("clr_rdy", {31'd0, rdy0}, 1);
        cyc(0, 0, 0, 0);
        chk("clr_noflush", {31'd0, oen0}, 0);

        // Asynchronous reset mid-run, between edges
        cyc(0, 1, 0, 64);
        cyc(0, 1, 0, 64);
        cyc(0, 1, 0, 64);
        i_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_idle_zero("arst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 1, 0, 64);
        chk("post_rst_e1", {31'd0, oen0}, 0);
        cyc(0, 1, 0, 64);
        chk("post_rst_e2", {31'd0, oen0}, 0);
        cyc(0, 1, 0, 64);
        chk("post_rst_e3", {31'd0, oen0}, 1);
        chk("post_rst_o3", out0, 64);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            bit r_clr, r_en, r_last;
            int x;
            r_clr  = ($urandom_range(99) < 3);
            r_en   = ($urandom_range(99) < 70);
            r_last = ($urandom_range(99) < 10);
            x      = int'($urandom_range(255)) - 128;
            cyc(r_clr, r_en, r_last, x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv1d_shift.md
CONV1D_SHIFT -- requirements
Module: conv1d_shift

Interface
REQ-001 Parameter DW, default 8: sample and result width, signed two's complement, range 4..16.
REQ-002 Parameter TAPS, default 3: filter length, range 2..8.
REQ-003 Parameter SHIFTS, default {3'd2,3'd1,3'd2}: packed 3*TAPS bits; field k is the arithmetic right-shift for tap k, where tap 0 is the newest sample.
REQ-004 Parameter SAT, default 1: 1 saturates the result to DW; 0 truncates it (wraps).
REQ-005 Parameter PRIME, default 1: 1 suppresses output until the window is full; 0 outputs from the first sample, with zeros in the empty taps.
REQ-006 clk  input  1  rising-edge clock, single domain.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 clr  input  1  synchronous clear, highest priority after rst.
REQ-009 in  input  DW  signed sample.
REQ-010 i_en  input  1  sample valid; accepted only when i_rdy=1.
REQ-011 i_last  input  1  marks the accepted sample as the last of a frame.
REQ-012 i_rdy  output  1  block can accept a sample this cycle.
REQ-013 out  output  DW  signed filtered result, registered.
REQ-014 o_en  output  1  out valid, one-cycle pulse per result.

Function
REQ-015 The window SHALL be a shift register w[0..TAPS-2] of prior samples; accepting a sample computes the result over {in, w[0..TAPS-2]} and then shifts in into w[0].
REQ-016 Result = sum over k of (tap_k >>> SHIFTS[k]), accumulated at DW+3 bits with sign extension before the adds.
REQ-017 SAT=1: a result above 2^(DW-1)-1 SHALL clamp to max, and below -2^(DW-1) SHALL clamp to min; SAT=0: keep the low DW bits.
REQ-018 Latency SHALL be 1: out and o_en update on the edge that accepts the sample; throughput is one sample per clock, back-to-back.
REQ-019 States SHALL be IDLE, FILL, RUN and FLUSH; a counter cnt (0..TAPS-1) tracks valid window entries.
REQ-020 IDLE: an accept moves to FILL, or to RUN when TAPS-1 = cnt+1 after the accept; i_rdy=1.
REQ-021 FILL: on each accept cnt increments; at cnt=TAPS-1 the state moves to RUN; o_en=0 while PRIME=1, o_en=1 per accept while PRIME=0.
REQ-022 RUN: each accept drives o_en=1.
REQ-023 Accepting with i_last=1 from any state SHALL enter FLUSH; that sample's own output follows REQ-021/022.
REQ-024 FLUSH: i_rdy=0, i_en is ignored, and one zero sample per cycle is injected for TAPS-1 cycles, each with o_en=1 (gated by PRIME only if the window never filled); the block then goes to IDLE with the window zeroed and cnt=0.
REQ-025 i_en=0 in IDLE, FILL or RUN SHALL hold state, window and out, with o_en=0.
REQ-026 clr=1 SHALL return to IDLE, zero the window, cnt, out and o_en, and override a simultaneous i_en or a flush in progress.
REQ-027 i_last with TAPS-1 flush cycles SHALL not overlap the next frame: i_rdy rises the cycle after the final flush output.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, window=0, cnt=0, out=0 and o_en=0; i_rdy SHALL then be 1.
REQ-029 rst asserted mid-FLUSH or mid-FILL SHALL abandon the operation with no further o_en pulses.
REQ-030 Reset deassertion SHALL need no specific cycle; the first accept may occur on the first edge after release.

Structure
REQ-031 A shared package conv1d_pkg SHALL hold the state encoding (IDLE=2'b00, FILL=2'b01, RUN=2'b10, FLUSH=2'b11), MAX_TAPS=8, the guard-bit constant 3 and the clog2 function.
REQ-032 The saturate/truncate stage SHALL be one sub-module, conv1d_sat (inputs DW+3 bits and SAT, output DW bits).

Verification
REQ-033 Defaults; 64,64,64 then i_last on a 4th sample of 64 -> o_en on samples 3 and 4 only, out=64,64; flush outputs 48, then 16; i_rdy=0 for 2 cycles.
REQ-034 SHIFTS={0,0,0}, 127 x3 -> SAT=1 gives out=127; SAT=0 gives out=125.
REQ-035 Defaults, -128 x3 -> out=-128; a window {-128,0,0} (newest first) gives -32.
REQ-036 PRIME=0, a single sample 64 with i_last -> out=16, then 32, then 16, each with o_en; then IDLE.
REQ-037 clr asserted during FLUSH cycle 1, together with i_en=1 -> next cycle IDLE, out=0, o_en=0, i_rdy=1; no flush output.
REQ-038 rst asserted asynchronously mid-RUN between edges -> outputs 0 immediately; after release, 3 samples of 64 are needed before the first o_en.
